// File: rtl/add_shift_mult_ctrl_if.sv
// Bus between the add-shift multiplier controller and its environment:
// run/load controls, switch input, adder select/sum path and result registers.
interface add_shift_mult_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             Run;
    logic             ClearA_LoadB;
    logic [WIDTH-1:0] Din;
    logic [WIDTH:0]   Sum;
    logic             Add;
    logic             Sub;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;
    logic             X;
    logic             Done;

    modport master (
        output Run,
        output ClearA_LoadB,
        output Din,
        output Sum,
        input  Add,
        input  Sub,
        input  A_out,
        input  B_out,
        input  X,
        input  Done
    );

    modport slave (
        input  Run,
        input  ClearA_LoadB,
        input  Din,
        input  Sum,
        output Add,
        output Sub,
        output A_out,
        output B_out,
        output X,
        output Done
    );
endinterface

// File: rtl/add_shift_mult_ctrl.sv
// Control and register unit of the 8x8 signed add-shift multiplier.
// Sequences 8 add/shift steps on {X,A,B}; the last add becomes a subtract.
module add_shift_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                 Clk,
    input logic                 Reset,
    add_shift_mult_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             add_en;

    // M bit selects the add; the 8th step carries negative weight.
    assign add_en = (state_q == S_ADD) & b_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ClearA_LoadB) begin
                    b_d = bus.Din;
                    a_d = '0;
                    x_d = 1'b0;
                end else if (bus.Run) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                a_d     = '0;
                x_d     = 1'b0;
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                if (b_q[0]) begin
                    {x_d, a_d} = bus.Sum;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_d   = {x_q, a_q[WIDTH-1:1]};
                b_d   = {a_q[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                if (!bus.Run) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus.Add   = add_en;
    assign bus.Sub   = add_en & (cnt_q == 3'd7);
    assign bus.A_out = a_q;
    assign bus.B_out = b_q;
    assign bus.X     = x_q;
    assign bus.Done  = (state_q == S_HOLD);
endmodule
